// File: rtl/sprite_anim_mapper_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg: shared types and constants for the sprite animation mapper.
//   coord_t     - 10-bit screen coordinate (DrawX/DrawY/pos_x/pos_y)
//   idx_t       - 5-bit palette index stored per texel
//   rgb_t       - 4-bit-per-channel colour
//   V_ACTIVE_DEF, FRAME_START_X - where the once-per-frame strobe fires
//   is_frame_start()            - frame strobe decode
//   texel_pattern()             - built-in ROM contents (index = addr+1 mod 32)
// -----------------------------------------------------------------------------
package sprite_pkg;
  localparam int COORD_W       = 10;
  localparam int IDX_W         = 5;
  localparam int COLOR_W       = 4;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int FRAME_START_X = 0;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // The strobe sits on the first blanked line so shadow/animation state never
  // changes while visible pixels are being drawn.
  function automatic logic is_frame_start(coord_t x, coord_t y, coord_t v_active);
    return (x == coord_t'(FRAME_START_X)) && (y == v_active);
  endfunction

  // Built-in artwork: a repeating ramp so every texel is predictable.
  function automatic idx_t texel_pattern(int unsigned a);
    return idx_t'(a + 1);
  endfunction
endpackage

// File: rtl/sprite_anim_mapper_if.sv
// -----------------------------------------------------------------------------
// sprite_anim_mapper_if: scan position, sprite control and pixel result bus.
//   DrawX/DrawY/blank  - current scan coordinate and active-video flag
//   pos_x/pos_y/flip_h - requested sprite placement and mirror
//   anim_en            - animation advance enable
//   sprite_hit/red/green/blue - registered pixel result
// master = video timing / compositor side, slave = the mapper.
// -----------------------------------------------------------------------------
interface sprite_anim_mapper_if;
  import sprite_pkg::*;

  coord_t             DrawX;
  coord_t             DrawY;
  logic               blank;
  coord_t             pos_x;
  coord_t             pos_y;
  logic               flip_h;
  logic               anim_en;
  logic               sprite_hit;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;

  modport master (
    output DrawX, DrawY, blank, pos_x, pos_y, flip_h, anim_en,
    input  sprite_hit, red, green, blue
  );

  modport slave (
    input  DrawX, DrawY, blank, pos_x, pos_y, flip_h, anim_en,
    output sprite_hit, red, green, blue
  );
endinterface

// File: rtl/sprite_frame_rom.sv
// -----------------------------------------------------------------------------
// sprite_frame_rom: texel index ROM holding all animation frames back to back.
// Ports: clk (read clock), addr_i (ADDR_W texel address), idx_o (5-bit palette
// index, valid one cycle after addr_i).
// -----------------------------------------------------------------------------
module sprite_frame_rom
  import sprite_pkg::*;
#(
  parameter int DEPTH  = 3780,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  output idx_t              idx_o
);

  idx_t rom_tbl [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    assign rom_tbl[i] = texel_pattern(i);
  end

  // NOTE: the read register has no reset; like a block RAM output it only
  // carries data, and qualifying hit/blank bits travel beside it and are reset.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    idx_o <= rom_tbl[addr_i];
  end

endmodule

// File: rtl/sprite_palette.sv
// -----------------------------------------------------------------------------
// sprite_palette: combinational 32-entry palette, index -> 12-bit colour.
// Ports: idx_i (palette index), rgb_o (colour).
// -----------------------------------------------------------------------------
module sprite_palette
  import sprite_pkg::*;
(
  input  idx_t idx_i,
  output rgb_t rgb_o
);

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    rgb_o   = '0;
    rgb_o.r = idx_i[3:0];
    rgb_o.g = idx_i[4:1];
    rgb_o.b = ~idx_i[3:0];
  end

endmodule

// File: rtl/sprite_anim_mapper.sv
// -----------------------------------------------------------------------------
// sprite_anim_mapper: maps the scan position onto an animated, scaled sprite.
// Ports: vga_clk (pixel clock), reset_n (synchronous, active-low),
//        bus (sprite_anim_mapper_if.slave: scan in, control in, pixel out).
// Pipeline: S1 hit/address, S2 ROM read, S3 palette + output register; outputs
// lag DrawX/DrawY/blank by exactly 3 cycles.
// Build option: define SPRITE_MIRROR_EN to enable horizontal mirroring (flip_h);
// otherwise flip_h is ignored.
// -----------------------------------------------------------------------------
module sprite_anim_mapper
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 21,
  parameter int SPR_H      = 45,
  parameter int FRAMES     = 4,
  parameter int SCALE_LOG2 = 2,
  parameter int FRAME_DIV  = 8,
  parameter int TRANSP_IDX = 0,
  parameter int V_ACTIVE   = V_ACTIVE_DEF
) (
  input logic                 vga_clk,
  input logic                 reset_n,
  sprite_anim_mapper_if.slave bus
);

  localparam int FRAME_TEXELS = SPR_W * SPR_H;
  localparam int ADDR_W       = $clog2(FRAMES * FRAME_TEXELS);
  localparam int FIDX_W       = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DIV_W        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic frame_start;
  assign frame_start = is_frame_start(bus.DrawX, bus.DrawY, coord_t'(V_ACTIVE));

  // ---------------- shadow position and animation counters ----------------
  coord_t             pos_x_s_q, pos_y_s_q;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [FIDX_W-1:0]  frame_idx_q, frame_idx_d;
  logic               mirror;

  always_comb begin
    div_cnt_d   = div_cnt_q;
    frame_idx_d = frame_idx_q;
    if (frame_start && bus.anim_en) begin
      if (div_cnt_q == DIV_W'(FRAME_DIV - 1)) begin
        div_cnt_d   = '0;
        frame_idx_d = (frame_idx_q == FIDX_W'(FRAMES - 1)) ? '0
                                                           : frame_idx_q + FIDX_W'(1);
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      pos_x_s_q   <= '0;
      pos_y_s_q   <= '0;
      div_cnt_q   <= '0;
      frame_idx_q <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      frame_idx_q <= frame_idx_d;
      if (frame_start) begin
        pos_x_s_q <= bus.pos_x;
        pos_y_s_q <= bus.pos_y;
      end
    end
  end

`ifdef SPRITE_MIRROR_EN
  logic flip_s_q;
  always_ff @(posedge vga_clk) begin
    if (!reset_n)         flip_s_q <= 1'b0;
    else if (frame_start) flip_s_q <= bus.flip_h;
  end
  assign mirror = flip_s_q;
`else
  logic unused_flip_h;
  assign unused_flip_h = bus.flip_h;
  assign mirror        = 1'b0;
`endif

  // ---------------- S1: hit test and texel address ----------------
  coord_t            dx, dy, lx_raw, lx, ly;
  logic              hit_s1_d;
  logic [ADDR_W-1:0] addr_s1_d;

  always_comb begin
    dx     = bus.DrawX - pos_x_s_q;
    dy     = bus.DrawY - pos_y_s_q;
    lx_raw = dx >> SCALE_LOG2;
    ly     = dy >> SCALE_LOG2;
    // The >= guards stop a coordinate left of/above the sprite from wrapping
    // into a small dx/dy.
    hit_s1_d = (bus.DrawX >= pos_x_s_q) && (bus.DrawY >= pos_y_s_q) &&
               (lx_raw < coord_t'(SPR_W)) && (ly < coord_t'(SPR_H));
    lx = mirror ? coord_t'(SPR_W - 1) - lx_raw : lx_raw;
    addr_s1_d = '0;
    if (hit_s1_d)
      addr_s1_d = ADDR_W'(frame_idx_q) * ADDR_W'(FRAME_TEXELS) +
                  ADDR_W'(ly) * ADDR_W'(SPR_W) + ADDR_W'(lx);
  end

  logic              s1_hit_q, s1_blank_q, s2_hit_q, s2_blank_q;
  logic [ADDR_W-1:0] s1_addr_q;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      s1_hit_q   <= 1'b0;
      s1_blank_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_hit_q   <= 1'b0;
      s2_blank_q <= 1'b0;
    end else begin
      s1_hit_q   <= hit_s1_d;
      s1_blank_q <= bus.blank;
      s1_addr_q  <= addr_s1_d;
      s2_hit_q   <= s1_hit_q;
      s2_blank_q <= s1_blank_q;
    end
  end

  // ---------------- S2: ROM read ----------------
  idx_t rom_idx;
  rgb_t pal_rgb;

  sprite_frame_rom #(
    .DEPTH (FRAMES * FRAME_TEXELS),
    .ADDR_W(ADDR_W)
  ) u_rom (
    .clk   (vga_clk),
    .addr_i(s1_addr_q),
    .idx_o (rom_idx)
  );

  // ---------------- S3: palette and output register ----------------
  sprite_palette u_pal (
    .idx_i(rom_idx),
    .rgb_o(pal_rgb)
  );

  logic hit_q, hit_d;
  rgb_t rgb_q, rgb_d;

  always_comb begin
    hit_d = 1'b0;
    rgb_d = '0;
    if (s2_blank_q && s2_hit_q && (rom_idx != idx_t'(TRANSP_IDX))) begin
      hit_d = 1'b1;
      rgb_d = pal_rgb;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hit_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      hit_q <= hit_d;
      rgb_q <= rgb_d;
    end
  end

  assign bus.sprite_hit = hit_q;
  assign bus.red        = rgb_q.r;
  assign bus.green      = rgb_q.g;
  assign bus.blue       = rgb_q.b;

endmodule

// File: tb/tb_sprite_anim_mapper.sv
// -----------------------------------------------------------------------------
// tb_sprite_anim_mapper: scoreboard bench for sprite_anim_mapper. Each driven
// pixel pushes its expected result (from a reference model of placement,
// scaling, animation and the built-in ramp artwork and palette) tagged with the
// cycle it must appear on; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_sprite_anim_mapper;
  import sprite_pkg::*;

`ifdef SPRITE_MIRROR_EN
  localparam bit MIRROR_EN = 1'b1;
`else
  localparam bit MIRROR_EN = 1'b0;
`endif

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  sprite_anim_mapper_if bus();

  sprite_anim_mapper #(
    .SPR_W(21), .SPR_H(45), .FRAMES(4), .SCALE_LOG2(2),
    .FRAME_DIV(8), .TRANSP_IDX(0), .V_ACTIVE(480)
  ) dut (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    string       tag;
    int          due;
    bit          hit;
    logic [11:0] rgb;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_bad   = 0;

  // reference model state
  int m_px = 0, m_py = 0, m_div = 0, m_frame = 0;
  bit m_flip = 1'b0;

  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model_pixel(int x, int y, bit b);
    exp_t e;
    int lx, ly, addr, idx;
    e.tag = "";
    e.due = 0;
    e.hit = 1'b0;
    e.rgb = '0;
    if (b && x >= m_px && y >= m_py) begin
      lx = (x - m_px) / 4;
      ly = (y - m_py) / 4;
      if (lx < 21 && ly < 45) begin
        if (m_flip) lx = 20 - lx;
        addr = m_frame * 945 + ly * 21 + lx;
        idx  = (addr + 1) % 32;
        if (idx != 0) begin
          e.hit = 1'b1;
          e.rgb = 12'(((idx % 16) << 8) | (((idx / 2) % 16) << 4) | (15 - (idx % 16)));
        end
      end
    end
    return e;
  endfunction

  // Drive one pixel for one cycle and queue its expected result.
  task automatic pixel(input string tag, input int x, input int y, input bit b,
                       input bit rst = 1'b0);
    exp_t e;
    @(posedge vga_clk);
    #1;
    bus.DrawX = coord_t'(x);
    bus.DrawY = coord_t'(y);
    bus.blank = b;
    reset_n   = !rst;
    e     = model_pixel(x, y, b);
    e.tag = tag;
    e.due = cyc + 3;
    if (rst) begin
      e.hit = 1'b0;
      e.rgb = '0;
      foreach (sb_q[i]) begin
        if (sb_q[i].due >= cyc + 1) begin
          sb_q[i].hit = 1'b0;
          sb_q[i].rgb = '0;
        end
      end
      m_px = 0; m_py = 0; m_flip = 1'b0; m_div = 0; m_frame = 0;
    end else if (x == 0 && y == 480) begin
      m_px   = int'(bus.pos_x);
      m_py   = int'(bus.pos_y);
      m_flip = MIRROR_EN && bus.flip_h;
      if (bus.anim_en) begin
        if (m_div == 7) begin
          m_div   = 0;
          m_frame = (m_frame + 1) % 4;
        end else begin
          m_div++;
        end
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic frame_strobe();
    pixel("fstart", 0, 480, 1'b1);
  endtask

  always @(negedge vga_clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check({e.tag, "_hit"}, {31'd0, bus.sprite_hit}, {31'd0, e.hit});
      check({e.tag, "_rgb"}, {20'd0, bus.red, bus.green, bus.blue}, {20'd0, e.rgb});
    end
  end

  initial begin
    bus.DrawX   = '0;
    bus.DrawY   = '0;
    bus.blank   = 1'b0;
    bus.pos_x   = 10'd100;
    bus.pos_y   = 10'd50;
    bus.flip_h  = 1'b0;
    bus.anim_en = 1'b0;

    // reset state
    repeat (3) pixel("in_rst", 5, 5, 1'b1, 1'b1);
    @(negedge vga_clk);
    check("rst_hit_now", {31'd0, bus.sprite_hit}, 32'd0);
    check("rst_rgb_now", {20'd0, bus.red, bus.green, bus.blue}, 32'd0);

    // placement at (100,50), frame 0
    frame_strobe();
    pixel("texel0",     100, 50,  1'b1);
    pixel("texel0_sub", 103, 53,  1'b1);
    pixel("x183_lx20",  183, 50,  1'b1);
    pixel("x184_out",   184, 50,  1'b1);
    pixel("transp",     140, 54,  1'b1);
    pixel("blank_in",   100, 50,  1'b0);
    pixel("last_row",   100, 226, 1'b1);
    pixel("below",      100, 230, 1'b1);
    pixel("left",        99, 50,  1'b1);
    pixel("above",      100, 49,  1'b1);

    // animation: 32 strobes wrap 0,1,2,3,0; then 12 more leave frame 1, div 4
    bus.anim_en = 1'b1;
    for (int k = 0; k < 44; k++) begin
      frame_strobe();
      pixel($sformatf("anim%0d", k), 100, 50, 1'b1);
    end
    bus.anim_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      frame_strobe();
      pixel($sformatf("frozen%0d", k), 100, 50, 1'b1);
    end
    // resume: 4 more strobes complete the held division -> frame 2
    bus.anim_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      frame_strobe();
      pixel($sformatf("resume%0d", k), 100, 50, 1'b1);
    end
    bus.anim_en = 1'b0;

    // mid-frame position change stays invisible until the next strobe
    bus.pos_x = 10'd200;
    pixel("mid_old", 100, 50, 1'b1);
    pixel("mid_new", 200, 50, 1'b1);
    frame_strobe();
    pixel("nf_old",  100, 50, 1'b1);
    pixel("nf_new",  200, 50, 1'b1);

    // mirror request (applied only in the mirror-enabled build)
    bus.flip_h = 1'b1;
    pixel("flip_pending", 200, 50, 1'b1);
    frame_strobe();
    pixel("flip_left",  200, 50, 1'b1);
    pixel("flip_right", 283, 50, 1'b1);
    bus.flip_h = 1'b0;

    // one-cycle reset mid-line while frame_idx = 2
    pixel("pre_rst0", 200, 50, 1'b1);
    pixel("pre_rst1", 204, 50, 1'b1);
    pixel("rst_mid",    0,  0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) pixel($sformatf("post_rst%0d", k), 0, 0, 1'b1);

    // drain the scoreboard with a bounded wait
    for (int g = 0; g < 20 && sb_q.size() > 0; g++) @(posedge vga_clk);
    check("drain_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_anim_mapper.md
SPRITE_ANIM_MAPPER -- requirements
Module: sprite_anim_mapper

Interface
REQ-001 SHALL have parameter SPR_W, 21, sprite width in texels.
REQ-002 SHALL have parameter SPR_H, 45, sprite height in texels.
REQ-003 SHALL have parameter FRAMES, 4, animation frames stored consecutively in ROM (frame f at offset f*SPR_W*SPR_H).
REQ-004 SHALL have parameter SCALE_LOG2, 2, each texel drawn as a 2^SCALE_LOG2 square of screen pixels.
REQ-005 SHALL have parameter FRAME_DIV, 8, video frames per animation step (>=1).
REQ-006 SHALL have parameter TRANSP_IDX, 0, palette index treated as transparent.
REQ-007 SHALL have parameter V_ACTIVE, 480, first non-visible line number.
REQ-008 SHALL have port vga_clk, input, 1, pixel clock; all logic on its rising edge.
REQ-009 SHALL have port reset_n, input, 1, reset; synchronous and active-low.
REQ-010 SHALL have ports DrawX, DrawY, input, 10 each, current scan coordinates.
REQ-011 SHALL have port blank, input, 1, 1 = active display, 0 = blanking.
REQ-012 SHALL have ports pos_x, pos_y, input, 10 each, requested sprite top-left screen position.
REQ-013 SHALL have port flip_h, input, 1, requested horizontal mirror.
REQ-014 SHALL have port anim_en, input, 1, 1 = animation advances.
REQ-015 SHALL have port sprite_hit, output, 1, opaque sprite pixel present on red/green/blue.
REQ-016 SHALL have ports red, green, blue, output, 4 each, pixel colour.

Function
REQ-017 SHALL define frame_start = (DrawX==0 && DrawY==V_ACTIVE), one cycle per video frame.
REQ-018 SHALL capture pos_x, pos_y, flip_h into shadow registers only on frame_start; mid-frame changes are invisible until the next frame_start.
REQ-019 SHALL compute dx = DrawX-pos_x_s, dy = DrawY-pos_y_s; hit when DrawX>=pos_x_s, DrawY>=pos_y_s, (dx>>SCALE_LOG2)<SPR_W, (dy>>SCALE_LOG2)<SPR_H; no wrap past screen coordinate 1023.
REQ-020 SHALL form lx = dx>>SCALE_LOG2 (or SPR_W-1-lx when mirrored), ly = dy>>SCALE_LOG2, address = frame_idx*SPR_W*SPR_H + ly*SPR_W + lx, width ADDR_W = $clog2(FRAMES*SPR_W*SPR_H); no dividers.
REQ-021 SHALL pipeline in three registered stages: S1 hit/address, S2 synchronous ROM read, S3 palette lookup and output register; fixed latency 3 cycles from DrawX/DrawY/blank to outputs.
REQ-022 SHALL delay hit and blank alongside data so outputs align with the pixel that produced them.
REQ-023 SHALL drive red/green/blue = palette colour and sprite_hit=1 only when delayed blank=1, delayed hit=1 and ROM index != TRANSP_IDX; otherwise red/green/blue=0 and sprite_hit=0.
REQ-024 SHALL, on frame_start with anim_en=1, increment div_cnt; when div_cnt reaches FRAME_DIV-1 it clears and frame_idx increments, wrapping FRAMES-1 -> 0.
REQ-025 SHALL hold div_cnt and frame_idx when anim_en=0; re-enabling resumes from held values.
REQ-026 SHALL update frame_idx only at frame_start so a frame never shows two animation frames.

Reset
REQ-027 SHALL, when reset_n=0 at a clock edge, clear red/green/blue, sprite_hit, all pipeline hit/blank bits, shadow registers, div_cnt and frame_idx to 0.
REQ-028 SHALL produce no sprite pixels for the 3 cycles after reset release until the pipeline refills; reset mid-line discards in-flight pixels.

Configuration
REQ-029 SHALL honour macro SPRITE_MIRROR_EN: defined -> flip_h captured and applied per REQ-020; undefined -> flip_h ignored, lx never mirrored, no mirror logic synthesised.

Structure
REQ-030 SHALL place the shared sprite package items (texel/index widths, colour width, V_ACTIVE default, frame_start helper constant) in package sprite_pkg.
REQ-031 SHALL use one sub-module sprite_frame_rom (synchronous, 1-cycle read, ADDR_W address, 5-bit index) plus an existing palette module; all counters and pipeline in the top.

Verification
REQ-032 SHALL test: pos=(100,50), frame 0, DrawX=100,DrawY=50 -> ROM address 0, colour of texel 0 appears exactly 3 cycles later.
REQ-033 SHALL test: DrawX=100+84=184 (=SPR_W<<2) -> sprite_hit=0, rgb=0; DrawX=183 -> hit, lx=20.
REQ-034 SHALL test: texel index == TRANSP_IDX -> sprite_hit=0, rgb=0 though inside bounds; blank=0 inside sprite -> rgb=0.
REQ-035 SHALL test: anim_en=1 for 32 frame_starts -> frame_idx steps every 8, sequence 0,1,2,3,0; anim_en=0 -> frame_idx frozen.
REQ-036 SHALL test: pos_x changed mid-frame -> rendered position unchanged until next frame_start; with SPRITE_MIRROR_EN and flip_h=1, DrawX=pos_x -> lx=20.
REQ-037 SHALL test: reset_n=0 for one cycle mid-line with frame_idx=2 -> next cycle all outputs 0, frame_idx=0, no hit for 3 cycles.
